// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (A, read-only) and the
//   data stage (B, read/write). Each access is LATENCY memory cycles, followed
//   by a single ack cycle and a return to IDLE. B has priority. After
//   MAX_B_STREAK consecutive contended B grants, the next contended grant goes
//   to A.
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   req_a    : fetch request, held until ack_a
//   req_b    : data request, held until ack_b
//   we_b     : B access is a write (sampled at grant only)
//   mem_sel  : address/wdata mux select, 1 = A, 0 = B
//   mem_en   : memory enable, high only in ACCESS
//   mem_we   : memory write enable, high only for B writes in ACCESS
//   ack_a    : one-cycle completion pulse to A
//   ack_b    : one-cycle completion pulse to B
//   busy     : high in ACCESS and ACK
module mem_port_arbiter #(
   parameter int LATENCY      = 2,
   parameter int MAX_B_STREAK = 3
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req_a,
   input  logic req_b,
   input  logic we_b,
   output logic mem_sel,
   output logic mem_en,
   output logic mem_we,
   output logic ack_a,
   output logic ack_b,
   output logic busy
);

   generate
      if (LATENCY < 1) begin : g_bad_latency
         $error("mem_port_arbiter: LATENCY must be >= 1");
      end
      if (MAX_B_STREAK < 1) begin : g_bad_streak
         $error("mem_port_arbiter: MAX_B_STREAK must be >= 1");
      end
   endgenerate

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int SW = $clog2(MAX_B_STREAK + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_B_STREAK);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   streak, streak_nxt;
   logic            owner_a;   // 1 = A owns the port, 0 = B
   logic            we_lat;    // write flag captured at grant
   logic            any_req;
   logic            grant_a;

   assign any_req = req_a | req_b;

   // A wins when alone, or when contended and B has used up its streak.
   assign grant_a = req_a & (~req_b | (streak >= STREAK_MAX));

   // The streak counts contended B wins only; any other outcome clears it.
   always_comb begin
      streak_nxt = '0;
      if (req_a && req_b && !grant_a)
         streak_nxt = streak + 1'b1;
   end

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant bookkeeping and access countdown
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         streak  <= '0;
         owner_a <= 1'b0;
         we_lat  <= 1'b0;
      end else begin
         if (state == IDLE && any_req) begin
            owner_a <= grant_a;
            we_lat  <= ~grant_a & we_b;
            cnt     <= CNT_LOAD;
            streak  <= streak_nxt;
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Outputs decode only from registers, so they change just after the clock
   // edge and drop immediately on reset. mem_sel tracks owner in every state,
   // which keeps the mux steady across IDLE and ACK.
   always_comb begin
      mem_sel = owner_a;
      mem_en  = 1'b0;
      mem_we  = 1'b0;
      ack_a   = 1'b0;
      ack_b   = 1'b0;
      busy    = 1'b0;
      case (state)
         ACCESS: begin
            mem_en = 1'b1;
            mem_we = ~owner_a & we_lat;
            busy   = 1'b1;
         end
         ACK: begin
            ack_a = owner_a;
            ack_b = ~owner_a;
            busy  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. dut is built with LATENCY=2,
// MAX_B_STREAK=2, and dut1 with LATENCY=1. Outputs are packed as
// {mem_sel, mem_en, mem_we, ack_a, ack_b, busy} and sampled 1 time unit
// after the rising edge.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic reset_n;
   logic req_a, req_b, we_b;
   logic ra1, rb1, wb1;
   logic mem_sel, mem_en, mem_we, ack_a, ack_b, busy;
   logic sel1, en1, we1, aa1, ab1, busy1;
   logic [5:0] o, o1;
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign o  = {mem_sel, mem_en, mem_we, ack_a, ack_b, busy};
   assign o1 = {sel1, en1, we1, aa1, ab1, busy1};

   mem_port_arbiter #(.LATENCY(2), .MAX_B_STREAK(2)) dut (
      .clk(clk), .reset_n(reset_n), .req_a(req_a), .req_b(req_b), .we_b(we_b),
      .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
      .ack_a(ack_a), .ack_b(ack_b), .busy(busy));

   mem_port_arbiter #(.LATENCY(1), .MAX_B_STREAK(3)) dut1 (
      .clk(clk), .reset_n(reset_n), .req_a(ra1), .req_b(rb1), .we_b(wb1),
      .mem_sel(sel1), .mem_en(en1), .mem_we(we1),
      .ack_a(aa1), .ack_b(ab1), .busy(busy1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_a = 0; req_b = 0; we_b = 0;
      ra1 = 0; rb1 = 0; wb1 = 0;
      #1;
      tests++;
      if (o !== 6'b000000 || o1 !== 6'b000000) begin
         fails++;
         $display("FAIL reset_state: got %b/%b want 000000/000000", o, o1);
      end
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      req_a = 1;
      tick();
      tests++;
      if (o !== 6'b110001) begin
         fails++; $display("FAIL reset_pre_access: got %b want 110001", o);
      end
      // Assert reset between edges while the access is in flight.
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (o !== 6'b000000) begin
         fails++; $display("FAIL reset_mid_access: got %b want 000000", o);
      end
      #2 reset_n = 1'b1;
      // req_a remains high and is arbitrated again from IDLE.
      tick();
      tests++;
      if (o !== 6'b110001) begin
         fails++; $display("FAIL reset_rearb_c1: got %b want 110001", o);
      end
      tick();
      tick();
      tests++;
      if (o !== 6'b100101) begin
         fails++; $display("FAIL reset_rearb_ack: got %b want 100101", o);
      end
      req_a = 0;
      tick();
      tests++;
      if (o !== 6'b100000) begin
         fails++; $display("FAIL reset_rearb_idle: got %b want 100000", o);
      end
   endtask

   task automatic test_read_a();
      logic [5:0] exp [4];
      exp[0] = 6'b110001; exp[1] = 6'b110001;
      exp[2] = 6'b100101; exp[3] = 6'b100000;
      req_a = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 2) req_a = 0;
         tests++;
         if (o !== exp[c]) begin
            fails++;
            $display("FAIL read_a_cycle%0d: got %b want %b", c + 1, o, exp[c]);
         end
      end
   endtask

   task automatic test_write_b();
      logic [5:0] exp [4];
      exp[0] = 6'b011001; exp[1] = 6'b011001;
      exp[2] = 6'b000011; exp[3] = 6'b000000;
      req_b = 1; we_b = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (c == 0) we_b = 0;   // changes after the grant have no effect
         if (c == 2) req_b = 0;
         tests++;
         if (o !== exp[c]) begin
            fails++;
            $display("FAIL write_b_cycle%0d: got %b want %b", c + 1, o, exp[c]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [5:0] exp [8];
      exp[0] = 6'b010001; exp[1] = 6'b010001; exp[2] = 6'b000011;
      exp[3] = 6'b000000; exp[4] = 6'b110001; exp[5] = 6'b110001;
      exp[6] = 6'b100101; exp[7] = 6'b100000;
      req_a = 1; req_b = 1; we_b = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 2) req_b = 0;
         if (c == 6) req_a = 0;
         tests++;
         if (o !== exp[c]) begin
            fails++;
            $display("FAIL simul_cycle%0d: got %b want %b", c + 1, o, exp[c]);
         end
      end
   endtask

   task automatic test_starvation();
      logic order [6];
      logic [5:0] e_acc, e_ack;
      order[0] = 0; order[1] = 0; order[2] = 1;
      order[3] = 0; order[4] = 0; order[5] = 1;
      req_a = 1; req_b = 1; we_b = 0;
      for (int g = 0; g < 6; g++) begin
         e_acc = {order[g], 5'b10001};
         e_ack = {order[g], 2'b00, order[g], ~order[g], 1'b1};
         tick();
         tests++;
         if (o !== e_acc) begin
            fails++;
            $display("FAIL starve_grant%0d_access: got %b want %b", g, o, e_acc);
         end
         tick();
         tick();
         tests++;
         if (o !== e_ack) begin
            fails++;
            $display("FAIL starve_grant%0d_ack: got %b want %b", g, o, e_ack);
         end
         if (g == 5) begin
            req_a = 0; req_b = 0;
         end
         tick();
      end
      tests++;
      if (o !== 6'b100000) begin
         fails++; $display("FAIL starve_final_idle: got %b want 100000", o);
      end
   endtask

   task automatic test_latency1();
      logic [5:0] exp [6];
      exp[0] = 6'b110001; exp[1] = 6'b100101; exp[2] = 6'b100000;
      exp[3] = 6'b011001; exp[4] = 6'b000011; exp[5] = 6'b000000;
      ra1 = 1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (c == 1) ra1 = 0;
         if (c == 2) begin
            rb1 = 1; wb1 = 1;
         end
         if (c == 4) begin
            rb1 = 0; wb1 = 0;
         end
         tests++;
         if (o1 !== exp[c]) begin
            fails++;
            $display("FAIL lat1_cycle%0d: got %b want %b", c + 1, o1, exp[c]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_a();
      test_write_b();
      test_simultaneous();
      test_starvation();
      test_latency1();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64-bit memory port between two requesters: instruction fetch (port A, read-only) and the data stage (port B, read/write).
- Sequences multi-cycle accesses and drives the `sel` input of the 64-bit 2:1 address and write-data muxes in front of the memory.
- Data (B) has priority. A starvation guard forces an A grant after a bounded run of B grants.

Parameters:
- LATENCY, 2, memory cycles per access; legal range is 1 or more, and elaboration fails if LATENCY < 1.
- MAX_B_STREAK, 3, consecutive contended B grants allowed before A is forced; legal range is 1 or more.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_a  input  1  fetch request; held until ack_a.
- req_b  input  1  data request; held until ack_b.
- we_b  input  1  B access is a write; valid while req_b is high.
- mem_sel  output  1  mux select; 1 = port A address, 0 = port B address and data.
- mem_en  output  1  memory enable for the access in flight.
- mem_we  output  1  memory write enable; only ever 1 for B writes.
- ack_a  output  1  one-cycle completion pulse to A.
- ack_b  output  1  one-cycle completion pulse to B.
- busy  output  1  high in ACCESS and ACK.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, cnt=0, streak=0, owner=B.
  - mem_sel=0, mem_en=0, mem_we=0, ack_a=0, ack_b=0, busy=0.
  - Reset mid-access abandons the access immediately and issues no ack.
- All outputs are registered. They are decoded from state, owner, and the latched we.
- States:
  - IDLE:
    - No request: stay.
    - Any request: latch the winner into owner (and latch we_b if owner=B), load cnt=LATENCY-1, go to ACCESS.
    - mem_sel holds the last owner value.
  - ACCESS:
    - mem_en=1, mem_sel=(owner==A), mem_we=latched we for B, 0 for A.
    - All three are stable for exactly LATENCY cycles.
    - When cnt==0, go to ACK; otherwise decrement cnt.
  - ACK:
    - ack_owner=1 for one cycle, mem_en=0, mem_we=0, mem_sel held.
    - Always return to IDLE, with no back-to-back issue from ACK.
- Timing: a request first sampled high in IDLE at edge T gives ACCESS in cycles T+1..T+LATENCY and the ack in cycle T+LATENCY+1. The next grant is decided at the edge after the ACK cycle. Each access occupies LATENCY+2 cycles.
- Arbitration at the IDLE decision edge:
  - Only one requester: that one wins.
  - Both requesting and streak<MAX_B_STREAK: B wins, streak++.
  - Both requesting and streak==MAX_B_STREAK: A wins, streak=0.
  - A wins for any reason: streak=0.
  - B wins uncontended (req_a=0): streak=0.
- Handshake rules:
  - Requesters drop req in the cycle after their ack. A req still high at the following IDLE edge is a new request.
  - A request withdrawn mid-access does not cancel it. The access completes and the ack still pulses.
  - we_b changes after the grant are ignored.
- ack_a and ack_b are never high simultaneously. mem_en is never high in IDLE or ACK.

Test Plan:
- Reset: assert reset_n=0 mid-ACCESS with LATENCY=2 -> all outputs 0 on the same cycle with no clock edge; after release, IDLE, and a held req_a is re-arbitrated normally.
- Single read on A, LATENCY=2: req_a rises before edge 0 -> mem_en=1, mem_sel=1 in cycles 1-2; ack_a=1 in cycle 3; busy=1 in cycles 1-3; mem_we=0 throughout.
- B write: req_b=1, we_b=1; we_b dropped during ACCESS -> mem_we=1, mem_sel=0 for all LATENCY cycles; one ack_b.
- Simultaneous requests: req_a=req_b=1 at the same edge -> B served first, then A at the next IDLE (A acked 4 cycles after B at LATENCY=2).
- Starvation guard, MAX_B_STREAK=2: req_a held, req_b re-asserted after every ack -> grant order B, B, A, B, B, A; streak back to 0 after each A.
- LATENCY=1 edge case: ACCESS lasts 1 cycle, ack in the cycle after the access; the ack pulse is exactly one cycle wide.
